// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter
//   Two requesters (A, B) share one 16-bit logical left shifter. A request
//   is granted in IDLE (ready asserted combinationally), the operand is
//   shifted in SHIFT, and the result is held in DONE until the consumer
//   accepts it.
//
// Parameters
//   PRIO_A    : 1 = A always wins when valid, 0 = round-robin between A and B
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   a_valid/a_ready     : requester A handshake
//   a_data, a_amt       : requester A operand and left-shift amount
//   b_*                 : same for requester B
//   out_valid/out_ready : result handshake
//   out_data, out_id    : shifted result and its source (0 = A, 1 = B)
//   busy                : high whenever the FSM is not in IDLE
//   op_count            : completed result handshakes, wraps at 256
module barrel_shift_arbiter #(
  parameter int unsigned PRIO_A = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [15:0] a_data,
  input  logic [3:0]  a_amt,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [15:0] b_data,
  input  logic [3:0]  b_amt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_id,
  output logic        busy,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_b;
  logic [15:0] r_op;
  logic [3:0]  r_amt;
  logic        r_cap_id;
  logic [15:0] r_out_data;
  logic        r_out_id;
  logic [7:0]  r_op_count;
  logic        w_grant_a;
  logic        w_grant_b;
  logic [15:0] w_shifted;

  // Grants only exist in IDLE and are masked by rst_n so the readies read
  // low for the whole reset pulse. A wins a tie under fixed priority or
  // when B was the last requester served.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (rst_n && r_state == IDLE) begin
      if (a_valid && (!b_valid || PRIO_A != 0 || r_last_b)) begin
        w_grant_a = 1'b1;
      end else if (b_valid) begin
        w_grant_b = 1'b1;
      end
    end
  end

  // Single shared shifter: zero fill, bits beyond bit 15 drop off.
  assign w_shifted = r_op << r_amt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_a || w_grant_b) w_next = SHIFT;
      SHIFT:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    a_ready   = w_grant_a;
    b_ready   = w_grant_b;
    out_valid = (r_state == DONE);
    busy      = (r_state != IDLE);
  end

  // Datapath: capture on grant, register the shift result in SHIFT,
  // count handshakes in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b   <= 1'b1;
      r_op       <= '0;
      r_amt      <= '0;
      r_cap_id   <= 1'b0;
      r_out_data <= '0;
      r_out_id   <= 1'b0;
      r_op_count <= '0;
    end else begin
      if (w_grant_a || w_grant_b) begin
        r_op     <= w_grant_b ? b_data : a_data;
        r_amt    <= w_grant_b ? b_amt : a_amt;
        r_cap_id <= w_grant_b;
        r_last_b <= w_grant_b;
      end
      if (r_state == SHIFT) begin
        r_out_data <= w_shifted;
        r_out_id   <= r_cap_id;
      end
      if (r_state == DONE && out_ready) begin
        r_op_count <= r_op_count + 8'd1;
      end
    end
  end

  assign out_data = r_out_data;
  assign out_id   = r_out_id;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
module tb_barrel_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] a_data = '0, b_data = '0;
  logic [3:0]  a_amt = '0, b_amt = '0;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [1:0]  a_rdy, b_rdy, o_vld, o_id, bsy;
  logic [15:0] o_data [2];
  logic [7:0]  o_cnt  [2];

  int total = 0;
  int bad   = 0;

  // Behavioural model state: phase 0 idle, 1 computing, 2 result held
  int          m_ph    [2];
  logic [15:0] m_d     [2];
  logic        m_id    [2];
  logic        m_lastb [2];
  int          m_cnt   [2];

  always #5 clk = ~clk;

  barrel_shift_arbiter #(.PRIO_A(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_rdy[0]), .a_data(a_data), .a_amt(a_amt),
    .b_valid(b_valid), .b_ready(b_rdy[0]), .b_data(b_data), .b_amt(b_amt),
    .out_valid(o_vld[0]), .out_ready(out_ready), .out_data(o_data[0]),
    .out_id(o_id[0]), .busy(bsy[0]), .op_count(o_cnt[0])
  );

  barrel_shift_arbiter #(.PRIO_A(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_rdy[1]), .a_data(a_data), .a_amt(a_amt),
    .b_valid(b_valid), .b_ready(b_rdy[1]), .b_data(b_data), .b_amt(b_amt),
    .out_valid(o_vld[1]), .out_ready(out_ready), .out_data(o_data[1]),
    .out_id(o_id[1]), .busy(bsy[1]), .op_count(o_cnt[1])
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  // 0 = no grant, 1 = A, 2 = B
  function automatic int gnt(int k);
    if (m_ph[k] != 0) return 0;
    if (a_valid && b_valid) return (k == 1 || m_lastb[k]) ? 1 : 2;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_d[k] = '0; m_id[k] = 1'b0; m_lastb[k] = 1'b1; m_cnt[k] = 0;
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      int g;
      g = rst_n ? gnt(k) : 0;
      chk($sformatf("a_ready%0d", k), a_rdy[k], g == 1);
      chk($sformatf("b_ready%0d", k), b_rdy[k], g == 2);
      chk($sformatf("out_valid%0d", k), o_vld[k], rst_n && m_ph[k] == 2);
      chk($sformatf("busy%0d", k), bsy[k], rst_n && m_ph[k] != 0);
      chk($sformatf("op_count%0d", k), o_cnt[k], rst_n ? m_cnt[k] : 0);
      if (!rst_n || m_ph[k] == 2) begin
        chk($sformatf("out_data%0d", k), o_data[k], rst_n ? m_d[k] : 16'h0);
        chk($sformatf("out_id%0d", k), o_id[k], rst_n ? m_id[k] : 1'b0);
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      int g;
      logic [31:0] prod;
      g = gnt(k);
      case (m_ph[k])
        0: if (g != 0) begin
          prod = (g == 2) ? {16'h0, b_data} * (32'd1 << b_amt)
                          : {16'h0, a_data} * (32'd1 << a_amt);
          m_d[k] = prod[15:0];
          m_id[k] = (g == 2);
          m_lastb[k] = (g == 2);
          m_ph[k] = 1;
        end
        1: m_ph[k] = 2;
        default: if (out_ready) begin
          m_ph[k] = 0;
          m_cnt[k] = (m_cnt[k] + 1) % 256;
        end
      endcase
    end
  endtask

  task automatic setin(input logic av, input logic [15:0] ad, input logic [3:0] aa,
                       input logic bv, input logic [15:0] bd, input logic [3:0] ba,
                       input logic ordy);
    @(negedge clk);
    a_valid = av; a_data = ad; a_amt = aa;
    b_valid = bv; b_data = bd; b_amt = ba;
    out_ready = ordy;
    #1;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle(input logic ordy);
    setin(1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0, ordy);
  endtask

  // Asynchronous reset asserted away from any clock edge, held across one
  // rising edge, released with no request pending.
  task automatic reset_pulse();
    rst_n = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    model_reset();
    #1;
    model_check();
    chk("rst_ready_a", a_rdy, 2'b00);
    chk("rst_ready_b", b_rdy, 2'b00);
    chk("rst_op_count", o_cnt[0], 8'd0);
    @(posedge clk);
    #1;
    model_check();
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic op_literal(input logic use_b, input logic [15:0] d, input logic [3:0] amt,
                            input logic [15:0] exp_d);
    if (use_b) setin(1'b0, 16'h0, 4'h0, 1'b1, d, amt, 1'b1);
    else       setin(1'b1, d, amt, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("lit_ready", {a_rdy[0], b_rdy[0]}, use_b ? 2'b01 : 2'b10);
    adv();
    idle(1'b1); adv();
    idle(1'b1);
    chk("lit_valid", o_vld[0], 1'b1);
    chk("lit_data", o_data[0], exp_d);
    chk("lit_id", o_id[0], use_b);
    adv();
  endtask

  initial begin
    logic [1:0] ids0 [$];
    logic [1:0] ids1 [$];
    model_reset();
    reset_pulse();

    // A: 0x0001 << 15, first grant right after reset release
    op_literal(1'b0, 16'h0001, 4'd15, 16'h8000);
    idle(1'b1);
    chk("lit_count1", o_cnt[0], 8'd1);
    adv();

    // B: 0xFFFF << 4, then 0x1234 << 0
    op_literal(1'b1, 16'hFFFF, 4'd4, 16'hFFF0);
    op_literal(1'b1, 16'h1234, 4'd0, 16'h1234);

    // Consumer stalls for 10 cycles while both requesters keep asking
    setin(1'b1, 16'h00FF, 4'd8, 1'b0, 16'h0, 4'h0, 1'b0); adv();
    idle(1'b0); adv();
    for (int i = 0; i < 10; i++) begin
      setin(1'b1, 16'($urandom), 4'($urandom), 1'b1, 16'($urandom), 4'($urandom), 1'b0);
      chk("stall_data", o_data[0], 16'hFF00);
      chk("stall_busy", bsy[0], 1'b1);
      chk("stall_ready", {a_rdy[0], b_rdy[0]}, 2'b00);
      adv();
    end
    idle(1'b1);
    chk("stall_release", o_vld[0], 1'b1);
    adv();
    idle(1'b1);
    chk("stall_idle", bsy[0], 1'b0);
    adv();

    // Reset pulsed while the result is being computed
    setin(1'b1, 16'h0F0F, 4'd3, 1'b0, 16'h0, 4'h0, 1'b1); adv();
    idle(1'b1);
    chk("shift_busy", bsy[0], 1'b1);
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("post_rst_valid", o_vld[0], 1'b0);
      adv();
    end

    // Both requesting continuously from reset
    reset_pulse();
    for (int i = 0; i < 12; i++) begin
      setin(1'b1, 16'(i), 4'd1, 1'b1, 16'(i + 100), 4'd2, 1'b1);
      if (o_vld[0]) ids0.push_back({1'b0, o_id[0]});
      if (o_vld[1]) ids1.push_back({1'b0, o_id[1]});
      adv();
    end
    chk("rr_count", ids0.size(), 4);
    chk("fp_count", ids1.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ids0.size()) chk("rr_id", ids0[i], i % 2);
      if (i < ids1.size()) chk("fp_id", ids1[i], 0);
    end

    // 256 completed operations wrap the counter
    reset_pulse();
    for (int c = 0; c < 768; c++) begin
      setin(1'b1, 16'($urandom), 4'($urandom), 1'b1, 16'($urandom), 4'($urandom), 1'b1);
      if (c == 765) chk("count_255", o_cnt[0], 8'd255);
      adv();
    end
    idle(1'b1);
    chk("count_wrap", o_cnt[0], 8'd0);
    adv();

    // Randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      setin(1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom), 4'($urandom),
            1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 199) == 0) reset_pulse();
      else adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
